// File: rtl/shared_wire_arbiter.sv
// Round-robin arbiter for a net shared by N tri-state drivers; enables at most one
// driver at a time and forces TURN_CYC all-off cycles between different ownerships.
module shared_wire_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] turn_cnt;
  logic [N-1:0]  gnt_q;
  logic [OW-1:0] pick;
  logic [N-1:0]  pick_onehot;
  logic          any_req;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
    wrap_inc = (v == OW'(N - 1)) ? '0 : v + OW'(1);
  endfunction

  // Walk ptr, ptr+1, ... modulo N and return the first index with a request.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] idx;
    logic          hit;
    idx     = p;
    hit     = 1'b0;
    rr_pick = p;
    for (int i = 0; i < N; i++) begin
      if (!hit && r[idx]) begin
        hit     = 1'b1;
        rr_pick = idx;
      end
      idx = wrap_inc(idx);
    end
  endfunction

  always_comb begin
    any_req     = |req;
    pick        = rr_pick(req, ptr);
    pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick;
  end

  assign gnt = gnt_q;
  assign oe  = gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        ST_GRANT: begin
          if (req[owner] && (cnt < CW'(HOLD_MAX))) begin
            cnt <= cnt + CW'(1);
          end else begin
            // owner is kept so the next arbitration starts just past it
            state    <= ST_TURN;
            gnt_q    <= '0;
            ptr      <= wrap_inc(owner);
            turn_cnt <= TW'(1);
          end
        end
        ST_TURN: begin
          if (turn_cnt == TW'(TURN_CYC)) begin
            if (any_req) begin
              state <= ST_GRANT;
              gnt_q <= pick_onehot;
              owner <= pick;
              cnt   <= CW'(1);
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: begin
          if (any_req) begin
            state <= ST_GRANT;
            gnt_q <= pick_onehot;
            owner <= pick;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_wire_arbiter.sv
// Bench for shared_wire_arbiter: one instance with defaults (dut_a) and one with
// HOLD_MAX=3, TURN_CYC=2 (dut_b) for the longer turnaround corner cases.
module tb_shared_wire_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b, oe_a, oe_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b;

  int tests    = 0;
  int failures = 0;

  logic [3:0] prev_g[2];
  int         run_len[2];
  int         zeros[2];
  bit         seen[2];

  vec_t tab_a[15];
  vec_t tab_b[17];

  shared_wire_arbiter #(.N(4), .HOLD_MAX(8), .TURN_CYC(1)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .gnt(gnt_a), .oe(oe_a), .owner(owner_a), .busy(busy_a)
  );

  shared_wire_arbiter #(.N(4), .HOLD_MAX(3), .TURN_CYC(2)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .gnt(gnt_b), .oe(oe_b), .owner(owner_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input bit sel, input logic r, input logic [3:0] q);
    @(negedge clk);
    if (sel) begin
      rst_b = r;
      req_b = q;
    end else begin
      rst_a = r;
      req_a = q;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input bit sel, input string name, input logic [3:0] eg,
                             input logic [1:0] eo, input logic eb);
    logic [3:0] g, o;
    logic [1:0] w;
    logic       b;
    if (sel) begin
      g = gnt_b; o = oe_b; w = owner_b; b = busy_b;
    end else begin
      g = gnt_a; o = oe_a; w = owner_a; b = busy_a;
    end
    tests++;
    if (g !== eg || o !== eg || w !== eo || b !== eb) begin
      failures++;
      $display("[TB] FAIL %s: got gnt=%b oe=%b owner=%0d busy=%b, expected gnt=oe=%b owner=%0d busy=%b",
               name, g, o, w, b, eg, eo, eb);
    end
  endtask

  task automatic checkInvariants(input int s, input logic [3:0] g, input logic [3:0] o,
                                 input int hold, input int turn);
    tests++;
    if (o !== g || !$onehot0(g)) begin
      failures++;
      $display("[TB] FAIL rand_onehot[%0d]: gnt=%b oe=%b", s, g, o);
    end
    if (g != 4'b0000) begin
      tests++;
      if (prev_g[s] != 4'b0000 && g != prev_g[s]) begin
        failures++;
        $display("[TB] FAIL rand_gap[%0d]: gnt %b followed %b with no gap, expected >= %0d zero cycles",
                 s, g, prev_g[s], turn);
      end else if (prev_g[s] == 4'b0000) begin
        if (seen[s] && zeros[s] < turn) begin
          failures++;
          $display("[TB] FAIL rand_gap[%0d]: gap of %0d zero cycles, expected >= %0d", s, zeros[s], turn);
        end
        run_len[s] = 1;
      end else begin
        run_len[s]++;
        if (run_len[s] > hold) begin
          failures++;
          $display("[TB] FAIL rand_hold[%0d]: run length %0d, expected <= %0d", s, run_len[s], hold);
        end
      end
      zeros[s] = 0;
      seen[s]  = 1'b1;
    end else begin
      zeros[s]++;
    end
    prev_g[s] = g;
  endtask

  task automatic run_hold(input logic [3:0] q, input string name);
    int         p;
    logic [1:0] own;
    logic [3:0] eg;
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput(1'b0, {name, "_reset"}, 4'b0000, 2'd0, 1'b0);
    for (int t = 1; t <= 38; t++) begin
      applyStimulus(1'b0, 1'b0, q);
      p   = (t - 1) % 9;
      own = (q == 4'b1111) ? 2'(((t - 1) / 9) % 4) : 2'd0;
      eg  = (p < 8) ? (4'b0001 << own) : 4'b0000;
      checkOutput(1'b0, $sformatf("%s_t%0d", name, t), eg, own, 1'b1);
    end
  endtask

  initial begin
    rst_a = 1'b1; req_a = 4'b0000;
    rst_b = 1'b1; req_b = 4'b0000;

    // dut_a: short request, fairness from ptr=3, reset mid-grant, re-arbitration
    tab_a[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tab_a[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tab_a[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tab_a[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tab_a[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1};
    tab_a[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tab_a[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tab_a[7]  = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1};
    tab_a[8]  = '{1'b0, 4'b0010, 4'b0000, 2'd3, 1'b1};
    tab_a[9]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tab_a[10] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1};
    tab_a[11] = '{1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0};
    tab_a[12] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
    tab_a[13] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1};
    tab_a[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

    // dut_b: two-cycle turnaround, late request during TURN, HOLD_MAX release to 1
    tab_b[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tab_b[1]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tab_b[2]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tab_b[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1};
    tab_b[4]  = '{1'b0, 4'b0010, 4'b0000, 2'd3, 1'b1};
    tab_b[5]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tab_b[6]  = '{1'b0, 4'b1000, 4'b0000, 2'd1, 1'b1};
    tab_b[7]  = '{1'b0, 4'b1000, 4'b0000, 2'd1, 1'b1};
    tab_b[8]  = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1};
    tab_b[9]  = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1};
    tab_b[10] = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1};
    tab_b[11] = '{1'b0, 4'b1010, 4'b0000, 2'd3, 1'b1};
    tab_b[12] = '{1'b0, 4'b1010, 4'b0000, 2'd3, 1'b1};
    tab_b[13] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    tab_b[14] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1};
    tab_b[15] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1};
    tab_b[16] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, tab_a[i].rst, tab_a[i].req);
      checkOutput(1'b0, $sformatf("vec_a%0d", i), tab_a[i].gnt, tab_a[i].owner, tab_a[i].busy);
    end
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, tab_b[i].rst, tab_b[i].req);
      checkOutput(1'b1, $sformatf("vec_b%0d", i), tab_b[i].gnt, tab_b[i].owner, tab_b[i].busy);
    end

    run_hold(4'b1111, "all_req");
    run_hold(4'b0001, "sole_req");

    // Random traffic on both instances with sticky requests for long holds
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; req_a = 4'b0000; req_b = 4'b0000;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    for (int s = 0; s < 2; s++) begin
      prev_g[s] = 4'b0000; run_len[s] = 0; zeros[s] = 0; seen[s] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 4'($urandom);
      @(posedge clk);
      #1;
      checkInvariants(0, gnt_a, oe_a, 8, 1);
      checkInvariants(1, gnt_b, oe_b, 3, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
